// File: rtl/alu_input_loader_if.sv
// Switch/button inputs and latched operand outputs of the ALU front-end loader.
// The board-side driver uses master; the loader itself uses slave.
interface alu_input_loader_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6,
    parameter int NB_BTN  = 3
);
    logic [NB_DATA-1:0] i_sw;
    logic [NB_BTN-1:0]  i_button;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_op;
    logic [NB_BTN-1:0]  o_loaded;
    logic               o_ready;

    modport master (
        output i_sw, i_button,
        input  o_data_a, o_data_b, o_op, o_loaded, o_ready
    );

    modport slave (
        input  i_sw, i_button,
        output o_data_a, o_data_b, o_op, o_loaded, o_ready
    );
endinterface

// File: rtl/alu_input_loader.sv
// Synchronises and debounces the three push buttons and latches the switch value
// into operand A, operand B or the opcode on each clean press.
module alu_input_loader #(
    parameter int NB_DATA   = 8,
    parameter int NB_OP     = 6,
    parameter int NB_BTN    = 3,
    parameter int DB_COUNT  = 1000000,
    parameter int NB_DB_CNT = 20
) (
    input  logic              clk,
    input  logic              i_reset,
    alu_input_loader_if.slave bus
);
    localparam logic [NB_DB_CNT-1:0] DB_LAST = NB_DB_CNT'(DB_COUNT - 1);

    logic [NB_BTN-1:0]  sync1_reg;
    logic [NB_BTN-1:0]  sync2_reg;
    logic [NB_BTN-1:0]  stable;
    logic [NB_BTN-1:0]  stable_d_reg;
    logic [NB_BTN-1:0]  press;
    logic [NB_DATA-1:0] data_a_reg;
    logic [NB_DATA-1:0] data_b_reg;
    logic [NB_OP-1:0]   op_reg;
    logic [NB_BTN-1:0]  loaded_reg;
    logic               ready_reg;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            sync1_reg    <= '0;
            sync2_reg    <= '0;
            stable_d_reg <= '0;
        end else begin
            sync1_reg    <= bus.i_button;
            sync2_reg    <= sync1_reg;
            stable_d_reg <= stable;
        end
    end

    // One independent debouncer per button: a level is accepted only after it
    // differs from the current stable level for DB_COUNT consecutive cycles.
    generate
        for (genvar gi = 0; gi < NB_BTN; gi++) begin : g_debounce
            logic                 stable_bit_reg;
            logic [NB_DB_CNT-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (i_reset) begin
                    stable_bit_reg <= 1'b0;
                    cnt_reg        <= '0;
                end else if (sync2_reg[gi] == stable_bit_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == DB_LAST) begin
                    stable_bit_reg <= sync2_reg[gi];
                    cnt_reg        <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign stable[gi] = stable_bit_reg;
        end
    endgenerate

    // Rising edge of the debounced level: one cycle per accepted press.
    assign press = stable & ~stable_d_reg;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            data_a_reg <= '0;
            data_b_reg <= '0;
            op_reg     <= '0;
            loaded_reg <= '0;
            ready_reg  <= 1'b0;
        end else begin
            if (press[0]) data_a_reg <= bus.i_sw;
            if (press[1]) data_b_reg <= bus.i_sw;
            if (press[2]) op_reg     <= bus.i_sw[NB_OP-1:0];
            loaded_reg <= loaded_reg | press;
            ready_reg  <= &loaded_reg;
        end
    end

    assign bus.o_data_a = data_a_reg;
    assign bus.o_data_b = data_b_reg;
    assign bus.o_op     = op_reg;
    assign bus.o_loaded = loaded_reg;
    assign bus.o_ready  = ready_reg;
endmodule

// File: tb/tb_alu_input_loader.sv
// Directed bench for alu_input_loader with a short debounce (DB_COUNT=4).
module tb_alu_input_loader;
    logic clk;
    logic i_reset;
    int   total;
    int   bad;

    alu_input_loader_if #(.NB_DATA(8), .NB_OP(6), .NB_BTN(3)) bus ();

    alu_input_loader #(
        .NB_DATA(8), .NB_OP(6), .NB_BTN(3), .DB_COUNT(4), .NB_DB_CNT(3)
    ) dut (
        .clk    (clk),
        .i_reset(i_reset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle, so samples sit away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        bus.i_sw = 8'h00;
        bus.i_button = 3'b000;
        idle(3);
        i_reset = 1'b0;
        total++;
        if ({bus.o_data_a, bus.o_data_b, bus.o_op, bus.o_loaded, bus.o_ready} !== 26'd0) begin
            bad++;
            $display("FAIL reset_state: got a=%h b=%h op=%h loaded=%b ready=%b want all 0",
                     bus.o_data_a, bus.o_data_b, bus.o_op, bus.o_loaded, bus.o_ready);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if ({bus.o_data_a, bus.o_data_b, bus.o_op, bus.o_loaded, bus.o_ready} !== 26'd0) begin
                bad++;
                $display("FAIL reset_idle cycle %0d: got a=%h b=%h op=%h loaded=%b ready=%b want all 0",
                         i, bus.o_data_a, bus.o_data_b, bus.o_op, bus.o_loaded, bus.o_ready);
            end
        end
        $display("test_reset: done");
    endtask

    task automatic test_load_a();
        bus.i_sw = 8'hA5;
        bus.i_button = 3'b001;
        for (int e = 1; e <= 6; e++) begin
            tick();
            total++;
            if (bus.o_data_a !== 8'h00 || bus.o_loaded !== 3'b000) begin
                bad++;
                $display("FAIL load_a_early edge %0d: got a=%h loaded=%b want a=00 loaded=000",
                         e, bus.o_data_a, bus.o_loaded);
            end
        end
        tick();  // edge 7
        total++;
        if (bus.o_data_a !== 8'hA5 || bus.o_loaded !== 3'b001) begin
            bad++;
            $display("FAIL load_a_edge7: got a=%h loaded=%b want a=a5 loaded=001",
                     bus.o_data_a, bus.o_loaded);
        end
        total++;
        if (bus.o_data_b !== 8'h00 || bus.o_op !== 6'h00 || bus.o_ready !== 1'b0) begin
            bad++;
            $display("FAIL load_a_others: got b=%h op=%h ready=%b want b=00 op=00 ready=0",
                     bus.o_data_b, bus.o_op, bus.o_ready);
        end
        bus.i_sw = 8'h3C;
        idle(3);
        total++;
        if (bus.o_data_a !== 8'hA5 || bus.o_ready !== 1'b0) begin
            bad++;
            $display("FAIL load_a_held: got a=%h ready=%b want a=a5 ready=0",
                     bus.o_data_a, bus.o_ready);
        end
        bus.i_button = 3'b000;
        bus.i_sw = 8'h00;
        idle(12);
        $display("test_load_a: a=%h loaded=%b", bus.o_data_a, bus.o_loaded);
    endtask

    task automatic test_glitch();
        bus.i_sw = 8'h77;
        for (int g = 0; g < 5; g++) begin
            bus.i_button = 3'b010;
            idle(3);
            bus.i_button = 3'b000;
            tick();
        end
        idle(10);
        total++;
        if (bus.o_data_b !== 8'h00 || bus.o_loaded[1] !== 1'b0) begin
            bad++;
            $display("FAIL glitch_b: got b=%h loaded[1]=%b want b=00 loaded[1]=0",
                     bus.o_data_b, bus.o_loaded[1]);
        end
        $display("test_glitch: b=%h loaded=%b", bus.o_data_b, bus.o_loaded);
    endtask

    task automatic test_simultaneous();
        bus.i_sw = 8'hFF;
        bus.i_button = 3'b110;
        idle(6);
        total++;
        if (bus.o_data_b !== 8'h00 || bus.o_op !== 6'h00) begin
            bad++;
            $display("FAIL sim_edge6: got b=%h op=%h want b=00 op=00", bus.o_data_b, bus.o_op);
        end
        tick();  // edge 7
        total++;
        if (bus.o_data_b !== 8'hFF || bus.o_op !== 6'h3F || bus.o_loaded !== 3'b111) begin
            bad++;
            $display("FAIL sim_edge7: got b=%h op=%h loaded=%b want b=ff op=3f loaded=111",
                     bus.o_data_b, bus.o_op, bus.o_loaded);
        end
        total++;
        if (bus.o_ready !== 1'b0 || bus.o_data_a !== 8'hA5) begin
            bad++;
            $display("FAIL sim_ready_early: got ready=%b a=%h want ready=0 a=a5",
                     bus.o_ready, bus.o_data_a);
        end
        tick();  // edge 8
        total++;
        if (bus.o_ready !== 1'b1) begin
            bad++;
            $display("FAIL sim_ready_edge8: got ready=%b want 1", bus.o_ready);
        end
        bus.i_button = 3'b000;
        bus.i_sw = 8'h00;
        idle(12);
        $display("test_simultaneous: b=%h op=%h ready=%b", bus.o_data_b, bus.o_op, bus.o_ready);
    endtask

    task automatic test_reset_abort();
        bus.i_sw = 8'h5A;
        bus.i_button = 3'b001;
        idle(3);
        i_reset = 1'b1;
        tick();  // edge 4 samples reset
        i_reset = 1'b0;
        total++;
        if ({bus.o_data_a, bus.o_data_b, bus.o_op, bus.o_loaded, bus.o_ready} !== 26'd0) begin
            bad++;
            $display("FAIL abort_reset_state: got a=%h b=%h op=%h loaded=%b ready=%b want all 0",
                     bus.o_data_a, bus.o_data_b, bus.o_op, bus.o_loaded, bus.o_ready);
        end
        for (int e = 1; e <= 6; e++) begin
            tick();
            total++;
            if (bus.o_data_a !== 8'h00 || bus.o_loaded !== 3'b000) begin
                bad++;
                $display("FAIL abort_early edge R+%0d: got a=%h loaded=%b want a=00 loaded=000",
                         e, bus.o_data_a, bus.o_loaded);
            end
        end
        tick();  // reset edge + 7
        total++;
        if (bus.o_data_a !== 8'h5A || bus.o_loaded !== 3'b001) begin
            bad++;
            $display("FAIL abort_reload: got a=%h loaded=%b want a=5a loaded=001",
                     bus.o_data_a, bus.o_loaded);
        end
        bus.i_button = 3'b000;
        bus.i_sw = 8'h00;
        idle(12);
        $display("test_reset_abort: a=%h loaded=%b", bus.o_data_a, bus.o_loaded);
    endtask

    task automatic test_back_to_back();
        bus.i_sw = 8'h12;
        bus.i_button = 3'b001;
        idle(10);
        total++;
        if (bus.o_data_a !== 8'h12 || bus.o_loaded[0] !== 1'b1) begin
            bad++;
            $display("FAIL repress_first: got a=%h loaded[0]=%b want a=12 loaded[0]=1",
                     bus.o_data_a, bus.o_loaded[0]);
        end
        bus.i_button = 3'b000;
        idle(10);
        total++;
        if (bus.o_data_a !== 8'h12 || bus.o_loaded[0] !== 1'b1) begin
            bad++;
            $display("FAIL repress_release: got a=%h loaded[0]=%b want a=12 loaded[0]=1",
                     bus.o_data_a, bus.o_loaded[0]);
        end
        bus.i_sw = 8'h34;
        bus.i_button = 3'b001;
        idle(10);
        total++;
        if (bus.o_data_a !== 8'h34 || bus.o_loaded[0] !== 1'b1) begin
            bad++;
            $display("FAIL repress_second: got a=%h loaded[0]=%b want a=34 loaded[0]=1",
                     bus.o_data_a, bus.o_loaded[0]);
        end
        bus.i_button = 3'b000;
        idle(10);
        $display("test_back_to_back: a=%h loaded=%b", bus.o_data_a, bus.o_loaded);
    endtask

    initial begin
        total = 0;
        bad = 0;
        i_reset = 1'b1;
        bus.i_sw = 8'h00;
        bus.i_button = 3'b000;
        test_reset();
        test_load_a();
        test_glitch();
        test_simultaneous();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
